// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: FIFO controller over an external 1-cycle-latency dual-port RAM,
// with a 2-entry output buffer so continuous pops see no bubbles.
module fifo_ram_ctrl #(
  parameter int words = 8,
  parameter int width = 8,
  localparam int addr_bits = $clog2(words)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [width-1:0]     wdata,
  output logic                 full,
  input  logic                 pop,
  output logic [width-1:0]     rdata,
  output logic                 rd_valid,
  output logic [addr_bits:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  output logic [addr_bits-1:0] ram_addr_a,
  output logic                 ram_wr_en_a,
  output logic [width-1:0]     ram_wdata_a,
  output logic [addr_bits-1:0] ram_addr_b,
  output logic                 ram_wr_en_b,
  output logic [width-1:0]     ram_wdata_b,
  input  logic [width-1:0]     ram_q_b
);
  logic [addr_bits:0]   count_q, count_d, ram_entries;
  logic [addr_bits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]           occ_q, occ_d, occ_s;
  logic                 inflight_q, inflight_d;
  logic [width-1:0]     buf0_q, buf0_d, buf1_q, buf1_d, buf0_s;
  logic                 overflow_q, overflow_d, underflow_q, underflow_d;
  logic                 acc_push, acc_pop, fetch, capture;

  always_comb begin
    full        = count_q == (addr_bits+1)'(words);
    rd_valid    = occ_q != 2'd0;
    acc_push    = push && !full && !flush;
    acc_pop     = pop && rd_valid && !flush;
    // entries still sitting in RAM: total minus those buffered or on their way out
    ram_entries = count_q - (addr_bits+1)'(occ_q) - (addr_bits+1)'(inflight_q);
    fetch       = !flush && ram_entries != '0 &&
                  ({1'b0, occ_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, acc_pop});
    capture     = inflight_q && !flush;
    occ_s       = occ_q - 2'(acc_pop);
    buf0_s      = acc_pop ? buf1_q : buf0_q;
    count_d     = flush ? '0 : count_q + (addr_bits+1)'(acc_push) - (addr_bits+1)'(acc_pop);
    wr_ptr_d    = flush ? '0 : wr_ptr_q + addr_bits'(acc_push);
    rd_ptr_d    = flush ? '0 : rd_ptr_q + addr_bits'(fetch);
    inflight_d  = fetch;
    buf0_d      = flush ? '0 : (capture && occ_s == 2'd0) ? ram_q_b : buf0_s;
    buf1_d      = flush ? '0 : (capture && occ_s == 2'd1) ? ram_q_b : buf1_q;
    occ_d       = flush ? 2'd0 : occ_s + 2'(capture);
    overflow_d  = push && full && !flush;
    underflow_d = pop && !rd_valid && !flush;
    ram_wr_en_a = acc_push && reset_n;
    ram_addr_a  = wr_ptr_q;
    ram_wdata_a = wdata;
    ram_addr_b  = rd_ptr_q;
    ram_wr_en_b = 1'b0;
    ram_wdata_b = '0;
    rdata       = buf0_q;
    count       = count_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb_fifo_ram_ctrl: directed vectors plus random traffic checked against a queue model.
module tb_fifo_ram_ctrl;
  localparam int WORDS = 8;
  localparam int WIDTH = 8;
  localparam int AB = $clog2(WORDS);

  logic clk = 1'b0, reset_n, flush, push, pop, full, rd_valid, overflow, underflow;
  logic ram_wr_en_a, ram_wr_en_b;
  logic [WIDTH-1:0] wdata, rdata, ram_wdata_a, ram_wdata_b, ram_q_b;
  logic [AB:0] count;
  logic [AB-1:0] ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] mem [WORDS];

  int checks = 0, errors = 0, wcnt = 0;
  logic [WIDTH-1:0] mq[$];
  bit e_ovf = 0, e_udf = 0;

  fifo_ram_ctrl #(.words(WORDS), .width(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .wdata(wdata),
    .full(full), .pop(pop), .rdata(rdata), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .underflow(underflow),
    .ram_addr_a(ram_addr_a), .ram_wr_en_a(ram_wr_en_a), .ram_wdata_a(ram_wdata_a),
    .ram_addr_b(ram_addr_b), .ram_wr_en_b(ram_wr_en_b), .ram_wdata_b(ram_wdata_b),
    .ram_q_b(ram_q_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en_a) mem[ram_addr_a] <= ram_wdata_a;
    ram_q_b <= mem[ram_addr_b];
  end

  typedef struct {
    bit p, q, f;
    logic [7:0] d;
    int e_count;
    bit e_valid;
    logic [7:0] e_rdata;
    bit e_ovf, e_udf;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input bit p, input bit q, input bit f, input logic [7:0] d);
    push = p; pop = q; flush = f; wdata = d;
    #1;
  endtask

  // Reference: a plain queue of accepted data; acceptance decided by the rules, not the RTL.
  task automatic model_step();
    bit fb, apush, apop;
    fb = mq.size() == WORDS;
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(fb));
    chk("overflow", int'(overflow), int'(e_ovf));
    chk("underflow", int'(underflow), int'(e_udf));
    chk("ram_wr_en_b", int'(ram_wr_en_b), 0);
    if (rd_valid) chk("valid_nonempty", int'(mq.size() > 0), 1);
    if (flush) begin
      chk("wr_en_flush", int'(ram_wr_en_a), 0);
      mq.delete(); wcnt = 0; e_ovf = 0; e_udf = 0;
    end else begin
      apop = pop && rd_valid;
      apush = push && !fb;
      chk("ram_wr_en_a", int'(ram_wr_en_a), int'(apush));
      if (apush) chk("ram_addr_a", int'(ram_addr_a), wcnt % WORDS);
      if (apop) begin
        chk("pop_data", int'(rdata), int'(mq[0]));
        void'(mq.pop_front());
      end
      if (apush) begin
        mq.push_back(wdata);
        wcnt++;
      end
      e_ovf = push && fb;
      e_udf = pop && !rd_valid;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit p, input bit q, input bit f, input logic [7:0] d);
    drive(p, q, f, d);
    model_step();
  endtask

  task automatic rand_run(input int n, input int flush_pct);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < flush_pct, 8'($urandom));
  endtask

  initial begin
    v[0] = '{1, 0, 0, 8'h11, 0, 0, 8'h00, 0, 0};
    v[1] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0};
    v[2] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0};
    v[3] = '{0, 0, 0, 8'h00, 1, 1, 8'h11, 0, 0};
    v[4] = '{0, 1, 0, 8'h00, 1, 1, 8'h11, 0, 0};
    v[5] = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    v[6] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1};
    v[7] = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    reset_n = 1'b0; push = 0; pop = 0; flush = 0; wdata = '0;
    repeat (2) @(negedge clk);
    push = 1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
    chk("rst_wr_en", int'(ram_wr_en_a), 0);
    push = 0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (v[i]) begin
      drive(v[i].p, v[i].q, v[i].f, v[i].d);
      chk($sformatf("vec%0d_count", i), int'(count), v[i].e_count);
      chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(v[i].e_valid));
      if (v[i].e_valid) chk($sformatf("vec%0d_rdata", i), int'(rdata), int'(v[i].e_rdata));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(v[i].e_ovf));
      chk($sformatf("vec%0d_udf", i), int'(underflow), int'(v[i].e_udf));
      model_step();
    end

    for (int i = 0; i < WORDS; i++) cyc(1, 0, 0, 8'(i));
    repeat (3) cyc(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), WORDS);
    model_step();
    drive(1, 1, 0, 8'hAA);
    chk("ovf_pop_valid", int'(rd_valid), 1);
    chk("ovf_pop_data", int'(rdata), 8'h00);
    model_step();
    drive(0, 0, 0, 0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), WORDS - 1);
    model_step();
    for (int i = 1; i < WORDS; i++) begin
      drive(0, 1, 0, 0);
      chk("drain_valid", int'(rd_valid), 1);
      chk("drain_data", int'(rdata), i);
      model_step();
    end

    for (int i = 0; i < WORDS; i++) cyc(1, 0, 0, 8'(i));
    repeat (3) cyc(0, 0, 0, 0);
    for (int i = 0; i < WORDS; i++) begin
      drive(0, 1, 0, 0);
      chk("stream_valid", int'(rd_valid), 1);
      chk("stream_data", int'(rdata), i);
      model_step();
    end
    drive(0, 0, 0, 0);
    chk("stream_empty", int'(count), 0);
    model_step();

    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h20 + i));
    repeat (3) cyc(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("pre_flush_data", int'(rdata), 8'h20);
    model_step();
    cyc(1, 1, 1, 8'hFF);
    drive(1, 0, 0, 8'h5A);
    chk("flush_count", int'(count), 0);
    chk("flush_valid", int'(rd_valid), 0);
    chk("flush_ovf", int'(overflow), 0);
    chk("flush_udf", int'(underflow), 0);
    model_step();
    for (int i = 1; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk("post_flush_wait", int'(rd_valid), 0);
      model_step();
    end
    drive(0, 1, 0, 0);
    chk("post_flush_valid", int'(rd_valid), 1);
    chk("post_flush_data", int'(rdata), 8'h5A);
    model_step();

    rand_run(20, 0);
    reset_n = 1'b0; push = 1; pop = 1; flush = 0;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(rd_valid), 0);
    chk("mid_rst_rdata", int'(rdata), 0);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_udf", int'(underflow), 0);
    chk("mid_rst_wr_en", int'(ram_wr_en_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete(); wcnt = 0; e_ovf = 0; e_udf = 0;
    cyc(1, 0, 0, 8'h3C);
    repeat (2) cyc(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("post_rst_valid", int'(rd_valid), 1);
    chk("post_rst_data", int'(rdata), 8'h3C);
    model_step();

    rand_run(600, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 Parameter words, default 8, SHALL set FIFO capacity in entries; legal only as a power of two, at least 4.
REQ-002 Parameter width, default 8, SHALL set the data width in bits; addr_bits = clog2(words).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be a synchronous clear of all FIFO contents.
REQ-006 push  input  1  SHALL be a write request; wdata  input  width  SHALL be the write data.
REQ-007 full  output  1  SHALL be asserted when count equals words.
REQ-008 pop  input  1  SHALL consume the head entry; rdata  output  width  SHALL be the head data; rd_valid  output  1  SHALL mean rdata is a valid head.
REQ-009 count  output  addr_bits+1  SHALL be the number of entries pushed but not yet popped.
REQ-010 overflow, underflow  output  1 each  SHALL be one-cycle error pulses.
REQ-011 ram_addr_a  output  addr_bits, ram_wr_en_a  output  1, ram_wdata_a  output  width  SHALL drive the dual-port RAM write port.
REQ-012 ram_addr_b  output  addr_bits, ram_wr_en_b  output  1, ram_wdata_b  output  width, ram_q_b  input  width  SHALL drive the RAM read port; the RAM returns data one clock after the address is presented.

Function
REQ-013 Accepted push SHALL be: push && !full && !flush, with full sampled from registered state at the start of the cycle.
REQ-014 ram_wr_en_a SHALL equal accepted push; ram_addr_a SHALL equal wr_ptr; ram_wdata_a SHALL equal wdata; wr_ptr SHALL increment modulo words per accepted push.
REQ-015 ram_wr_en_b SHALL be constant 0 and ram_wdata_b constant 0; ram_addr_b SHALL equal rd_ptr.
REQ-016 The output stage SHALL be a 2-entry buffer; rdata/rd_valid SHALL reflect its head entry.
REQ-017 A fetch SHALL be issued when ram_entries > 0 and (out_occupancy + inflight - accepted_pop) < 2; a fetch increments rd_ptr modulo words and sets inflight for one cycle.
REQ-018 An entry written in cycle N SHALL NOT be fetched before cycle N+1.
REQ-019 Inflight data SHALL be captured from ram_q_b into the output buffer at the end of the cycle after fetch issue.
REQ-020 Accepted pop SHALL be: pop && rd_valid && !flush; it removes the head entry and advances the buffer.
REQ-021 Latency: a push into an empty FIFO in cycle N SHALL give rd_valid=1 with that data in cycle N+3.
REQ-022 Throughput: with the FIFO holding at least 3 entries, continuous pop SHALL be accepted every cycle.
REQ-023 count SHALL update +1 per accepted push and -1 per accepted pop, and be unchanged when both occur in the same cycle.
REQ-024 A push while full SHALL NOT write and SHALL pulse overflow the next cycle; a simultaneous pop while full SHALL still be accepted.
REQ-025 A pop with rd_valid=0 SHALL pulse underflow the next cycle; a simultaneous push SHALL be accepted.
REQ-026 When flush is asserted, the next edge SHALL zero wr_ptr, rd_ptr, count and the output buffer and clear inflight; RAM data returning afterwards SHALL be discarded, and push/pop in the flush cycle SHALL be ignored without error pulses.
REQ-027 Pointer wrap from words-1 to 0 SHALL preserve FIFO order.

Reset
REQ-028 While reset_n=0, regardless of clk: count=0, full=0, rd_valid=0, rdata=0, overflow=0, underflow=0, wr_ptr=0, rd_ptr=0, inflight=0, ram_wr_en_a=0.
REQ-029 Reset asserted mid-operation SHALL discard all contents and inflight reads; the first edge after deassertion SHALL behave as from empty.

Verification
REQ-030 Push 0x11 at cycle 0 into an empty FIFO -> rd_valid=1 and rdata=0x11 at cycle 3; count=1 from cycle 1.
REQ-031 With words=8, push 0x00..0x07 -> full=1 and count=8; then push 0xAA together with pop -> 0x00 popped, 0xAA dropped, overflow pulse, count=7.
REQ-032 With the FIFO filled, pop continuously for 8 cycles -> data 0x00..0x07 in order, rd_valid=1 throughout, no bubbles.
REQ-033 Pop on an empty FIFO -> underflow pulse for 1 cycle, count stays 0.
REQ-034 Push 5 entries, flush while a fetch is inflight -> the next cycle count=0 and rd_valid=0; a new push 0x5A is read first at +3 cycles.
REQ-035 Run 20 random push/pop wrap cycles, then assert reset_n=0 mid-stream -> outputs clear immediately; after release the FIFO behaves as empty.
